radio_bridge_seq: RTL

//  Parametrised successor bridge between PHY cores and one radio board carrying NUM_CH I/Q converter channels.

---
 rtl/radio_bridge_seq.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/radio_bridge_seq.sv
// Radio board bridge: registered DAC/ADC paths plus a single Tx/Rx sequencer (TxEn/RxEn, radio_B, Tx gain).
// Define RADIO_BRIDGE_GAIN_RAMP_EN for 1-LSB Tx gain ramping; otherwise gain changes take effect in one cycle.
module radio_bridge_seq #(
  parameter int NUM_CH           = 2,
  parameter int DAC_WIDTH        = 16,
  parameter int ADC_WIDTH        = 14,
  parameter int TX_SETTLE_CYCLES = 40,
  parameter int GAIN_STEP_CYCLES = 4
) (
  input  logic                          converter_clock_in,
  input  logic                          converter_reset_n,
  input  logic                          user_tx_req,
  input  logic                          user_rx_req,
  input  logic [5:0]                    user_Tx_gain,
  input  logic [1:0]                    user_RxRF_gain,
  input  logic [4:0]                    user_RxBB_gain,
  input  logic [NUM_CH*DAC_WIDTH-1:0]   user_DAC_I,
  input  logic [NUM_CH*DAC_WIDTH-1:0]   user_DAC_Q,
  input  logic [NUM_CH*ADC_WIDTH-1:0]   radio_ADC_I,
  input  logic [NUM_CH*ADC_WIDTH-1:0]   radio_ADC_Q,
  output logic [NUM_CH*DAC_WIDTH-1:0]   radio_DAC_I,
  output logic [NUM_CH*DAC_WIDTH-1:0]   radio_DAC_Q,
  output logic [NUM_CH*ADC_WIDTH-1:0]   user_ADC_I,
  output logic [NUM_CH*ADC_WIDTH-1:0]   user_ADC_Q,
  output logic                          user_ADC_valid,
  output logic                          user_tx_ready,
  output logic                          radio_TxEn,
  output logic                          radio_RxEn,
  output logic [6:0]                    radio_B,
  output logic [2:0]                    seq_state
);

  localparam int CNT_MAX = (TX_SETTLE_CYCLES > GAIN_STEP_CYCLES) ? TX_SETTLE_CYCLES : GAIN_STEP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(TX_SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RX           = 3'd1,
    TX_EN        = 3'd2,
    TX_RAMP_UP   = 3'd3,
    TX_ACTIVE    = 3'd4,
    TX_RAMP_DOWN = 3'd5
  } state_t;

`ifdef RADIO_BRIDGE_GAIN_RAMP_EN
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(GAIN_STEP_CYCLES - 1);

  function automatic logic [5:0] sat_inc(input logic [5:0] g);
    return (g == 6'd63) ? g : g + 6'd1;
  endfunction

  function automatic logic [5:0] sat_dec(input logic [5:0] g);
    return (g == 6'd0) ? g : g - 6'd1;
  endfunction
`endif

  state_t                        state_q, state_d;
  logic [5:0]                    gain_q, gain_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          cnt_clr;
  logic                          txen_q, rxen_q, ready_q;
  logic [6:0]                    b_q, b_d;
  logic [NUM_CH*DAC_WIDTH-1:0]   dac_i_q, dac_q_q;
  logic [NUM_CH*ADC_WIDTH-1:0]   adc_i_p0_q, adc_q_p0_q, adc_i_p1_q, adc_q_p1_q;
  logic                          vld_p0_q, vld_p1_q;
  logic                          tx_path_d;

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        gain_d = 6'd0;
        if (user_tx_req)      state_d = TX_EN;
        else if (user_rx_req) state_d = RX;
      end
      RX: begin
        if (!user_rx_req || user_tx_req) state_d = IDLE;
      end
      TX_EN: begin
        gain_d = 6'd0;
        if (!user_tx_req)              state_d = IDLE;
        else if (cnt_q == SETTLE_LAST) state_d = TX_RAMP_UP;
      end
      TX_RAMP_UP: begin
        if (!user_tx_req) begin
          state_d = TX_RAMP_DOWN;
        end else begin
`ifdef RADIO_BRIDGE_GAIN_RAMP_EN
          if (gain_q >= user_Tx_gain) begin
            state_d = TX_ACTIVE;
          end else if (cnt_q == STEP_LAST) begin
            gain_d  = sat_inc(gain_q);
            cnt_clr = 1'b1;
            if (gain_d == user_Tx_gain) state_d = TX_ACTIVE;
          end
`else
          gain_d  = user_Tx_gain;
          state_d = TX_ACTIVE;
`endif
        end
      end
      TX_ACTIVE: begin
        if (!user_tx_req) begin
          state_d = TX_RAMP_DOWN;
        end else begin
`ifdef RADIO_BRIDGE_GAIN_RAMP_EN
          if (cnt_q == STEP_LAST) begin
            cnt_clr = 1'b1;
            if (gain_q < user_Tx_gain)      gain_d = sat_inc(gain_q);
            else if (gain_q > user_Tx_gain) gain_d = sat_dec(gain_q);
          end
`else
          gain_d = user_Tx_gain;
`endif
        end
      end
      TX_RAMP_DOWN: begin
        // tx_req is deliberately not looked at here: the ramp always finishes in IDLE
`ifdef RADIO_BRIDGE_GAIN_RAMP_EN
        if (cnt_q == STEP_LAST) begin
          gain_d  = sat_dec(gain_q);
          cnt_clr = 1'b1;
        end
        if (gain_d == 6'd0) state_d = IDLE;
`else
        gain_d  = 6'd0;
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        gain_d  = 6'd0;
      end
    endcase

    if (cnt_clr || (state_d != state_q) || (state_q == IDLE) || (state_q == RX))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;

    tx_path_d = (state_d == TX_RAMP_UP) || (state_d == TX_ACTIVE) || (state_d == TX_RAMP_DOWN);
    b_d       = (state_d == RX) ? {user_RxRF_gain, user_RxBB_gain} : {1'b0, gain_d};
  end

  // Control outputs are registered from the next state so they change on the state-entry edge
  always_ff @(posedge converter_clock_in) begin
    if (!converter_reset_n) begin
      state_q <= IDLE;
      gain_q  <= 6'd0;
      cnt_q   <= '0;
      txen_q  <= 1'b0;
      rxen_q  <= 1'b0;
      ready_q <= 1'b0;
      b_q     <= 7'd0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
      txen_q  <= (state_d == TX_EN) || tx_path_d;
      rxen_q  <= (state_d == RX);
      ready_q <= (state_d == TX_ACTIVE);
      b_q     <= b_d;
    end
  end

  // Data paths: DAC one stage, ADC two stages with valid riding alongside
  always_ff @(posedge converter_clock_in) begin
    if (!converter_reset_n) begin
      dac_i_q    <= '0;
      dac_q_q    <= '0;
      adc_i_p0_q <= '0;
      adc_q_p0_q <= '0;
      adc_i_p1_q <= '0;
      adc_q_p1_q <= '0;
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
    end else begin
      dac_i_q    <= tx_path_d ? user_DAC_I : '0;
      dac_q_q    <= tx_path_d ? user_DAC_Q : '0;
      adc_i_p0_q <= radio_ADC_I;
      adc_q_p0_q <= radio_ADC_Q;
      adc_i_p1_q <= adc_i_p0_q;
      adc_q_p1_q <= adc_q_p0_q;
      vld_p0_q   <= (state_q == RX);
      vld_p1_q   <= vld_p0_q;
    end
  end

  assign radio_DAC_I    = dac_i_q;
  assign radio_DAC_Q    = dac_q_q;
  assign user_ADC_I     = adc_i_p1_q;
  assign user_ADC_Q     = adc_q_p1_q;
  assign user_ADC_valid = vld_p1_q;
  assign user_tx_ready  = ready_q;
  assign radio_TxEn     = txen_q;
  assign radio_RxEn     = rxen_q;
  assign radio_B        = b_q;
  assign seq_state      = state_q;

  a_txen_rxen_exclusive: assert property (@(posedge converter_clock_in)
    disable iff (!converter_reset_n) !(txen_q && rxen_q));

endmodule
